// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of uart_tx_fifo: data/strobe in, ready/level/overflow back.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] i_dat;
    logic                 i_write;
    logic                 o_ready;
    logic [LVL_W-1:0]     o_level;
    logic                 o_overflow;

    modport master (
        output i_dat, i_write,
        input  o_ready, o_level, o_overflow
    );

    modport slave (
        input  i_dat, i_write,
        output o_ready, o_level, o_overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-fed serial transmitter: configurable width, runtime parity/stop/divisor,
// host RTS_n honoured only at frame boundaries.
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [DIV_WIDTH-1:0] i_cycles_per_bit,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_two_stop,
    input  logic                 i_rts_n,
    output logic                 o_sout,
    output logic                 o_busy,
    uart_tx_fifo_if.slave        wr
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 overflow_q;

    state_e               state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [BIT_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 par_en_q;
    logic                 two_stop_q;
    logic                 stop2_q;
    logic                 sout_q;
    logic                 busy_q;

    logic                 full_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 bit_end_c;
    logic                 frame_end_c;
    logic [DIV_WIDTH-1:0] div_eff_c;
    logic [DATA_BITS-1:0] rd_word_c;

    // Handshake, pop decision and FIFO bookkeeping
    always_comb begin
        full_c      = (level_q == LVL_W'(FIFO_DEPTH));
        push_c      = wr.i_write & ~full_c;
        bit_end_c   = (cnt_q == div_q - DIV_WIDTH'(1));
        frame_end_c = (state_q == S_STOP) && bit_end_c && (!two_stop_q || stop2_q);
        pop_c       = (level_q != '0) && !i_rts_n && ((state_q == S_IDLE) || frame_end_c);
        div_eff_c   = (i_cycles_per_bit < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_cycles_per_bit;
        rd_word_c   = mem[rd_ptr_q];

        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= wr.i_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (wr.i_write && full_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Frame sequencer; a pop (from IDLE or at stop end) launches the next start bit
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_WIDTH'(2);
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            sout_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else if (pop_c) begin
            state_q    <= S_START;
            cnt_q      <= '0;
            div_q      <= div_eff_c;
            bit_idx_q  <= '0;
            shift_q    <= rd_word_c;
            parity_q   <= (^rd_word_c) ^ (i_parity_mode == 2'b10);
            par_en_q   <= (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
            two_stop_q <= i_two_stop;
            stop2_q    <= 1'b0;
            sout_q     <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sout_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                S_START: begin
                    if (bit_end_c) begin
                        state_q   <= S_DATA;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        sout_q    <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        cnt_q <= '0;
                        if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                sout_q  <= parity_q;
                            end else begin
                                state_q <= S_STOP;
                                stop2_q <= 1'b0;
                                sout_q  <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_W'(1);
                            sout_q    <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end_c) begin
                        state_q <= S_STOP;
                        cnt_q   <= '0;
                        stop2_q <= 1'b0;
                        sout_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end_c) begin
                        cnt_q <= '0;
                        if (two_stop_q && !stop2_q) begin
                            stop2_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            sout_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    sout_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sout        = sout_q;
    assign o_busy        = busy_q;
    assign wr.o_ready    = ~full_c;
    assign wr.o_level    = level_q;
    assign wr.o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of written bytes against decoded frames.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpb;
    logic [1:0]  pm;
    logic        ts;
    logic        rts_n;
    logic        sout;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus ();

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_cycles_per_bit (cpb),
        .i_parity_mode    (pm),
        .i_two_stop       (ts),
        .i_rts_n          (rts_n),
        .o_sout           (sout),
        .o_busy           (busy),
        .wr               (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.i_dat   = b;
        bus.i_write = 1'b1;
        sb.push_back(b);
        tick();
        bus.i_write = 1'b0;
    endtask

    task automatic wait_start(input int max_cyc, output int waited, input string name);
        waited = 0;
        while (sout !== 1'b0 && waited < max_cyc) begin
            tick();
            waited++;
        end
        checks++;
        if (sout !== 1'b0) begin
            errors++;
            $display("FAIL %s start: sout=%b after %0d cycles, required 0", name, sout, waited);
        end
    endtask

    // Compares every cycle of one frame against a bench-built bit list.
    task automatic check_frame(input int d, input logic [1:0] pmode, input logic two, input string name);
        logic [7:0]  data;
        logic [11:0] bits;
        int nb, bad, first_bad, busy_cnt;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, no expected byte", name);
            return;
        end
        data = sb.pop_front();
        bits = '1;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = data[i]; nb++;
        end
        if (pmode == 2'b01) begin bits[nb] = ^data;  nb++; end
        if (pmode == 2'b10) begin bits[nb] = ~^data; nb++; end
        bits[nb] = 1'b1; nb++;
        if (two) begin bits[nb] = 1'b1; nb++; end
        bad = 0; first_bad = -1; busy_cnt = 0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < d; c++) begin
                if (sout !== bits[b]) begin
                    if (bad == 0) first_bad = b * d + c;
                    bad++;
                end
                if (busy === 1'b1) busy_cnt++;
                tick();
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s wave: data %02h, %0d bad cycles, first at cycle %0d, required 0 bad", name, data, bad, first_bad);
        end
        checks++;
        if (busy_cnt != nb * d) begin
            errors++;
            $display("FAIL %s busy: %0d busy cycles, required %0d", name, busy_cnt, nb * d);
        end
    endtask

    task automatic check_idle(input string name, input logic [4:0] lvl);
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0 || bus.o_level !== lvl) begin
            errors++;
            $display("FAIL %s idle: sout=%b busy=%b level=%0d, required 1 0 %0d", name, sout, busy, bus.o_level, lvl);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (sout !== 1'b1) begin errors++; $display("FAIL reset sout: %b, required 1", sout); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: %b, required 0", busy); end
        checks++;
        if (bus.o_level !== 5'd0) begin errors++; $display("FAIL reset level: %0d, required 0", bus.o_level); end
        checks++;
        if (bus.o_overflow !== 1'b0 || bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset ovf/ready: %b %b, required 0 1", bus.o_overflow, bus.o_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_8n1();
        apply_reset();
        cpb = 16'd32; pm = 2'b00; ts = 1'b0; rts_n = 1'b0;
        write_byte(8'hA5);
        checks++;
        if (bus.o_level !== 5'd1 || sout !== 1'b1) begin
            errors++;
            $display("FAIL 8n1 write: level=%0d sout=%b, required 1 1", bus.o_level, sout);
        end
        tick();
        checks++;
        if (sout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL 8n1 latency: sout=%b busy=%b, required 0 1", sout, busy);
        end
        check_frame(32, 2'b00, 1'b0, "8n1");
        check_idle("8n1 end", 5'd0);
    endtask

    task automatic test_parity();
        int w;
        apply_reset();
        cpb = 16'd4; pm = 2'b01; ts = 1'b1; rts_n = 1'b0;
        write_byte(8'h07);
        wait_start(3, w, "8e2");
        check_frame(4, 2'b01, 1'b1, "8e2");
        check_idle("8e2 end", 5'd0);
        pm = 2'b10; ts = 1'b0;
        write_byte(8'h07);
        wait_start(3, w, "8o1");
        check_frame(4, 2'b10, 1'b0, "8o1");
        check_idle("8o1 end", 5'd0);
    endtask

    task automatic test_rts();
        int held;
        apply_reset();
        cpb = 16'd4; pm = 2'b00; ts = 1'b0; rts_n = 1'b1;
        write_byte(8'h11);
        write_byte(8'h22);
        tick();
        tick();
        check_idle("rts blocked", 5'd2);
        rts_n = 1'b0;
        tick();
        checks++;
        if (sout !== 1'b0) begin errors++; $display("FAIL rts release: sout=%b, required 0", sout); end
        rts_n = 1'b1;
        check_frame(4, 2'b00, 1'b0, "rts first");
        check_idle("rts mid", 5'd1);
        held = 0;
        for (int i = 0; i < 20; i++) begin
            if (sout === 1'b1 && busy === 1'b0) held++;
            tick();
        end
        checks++;
        if (held != 20) begin errors++; $display("FAIL rts hold: %0d idle cycles, required 20", held); end
        rts_n = 1'b0;
        tick();
        checks++;
        if (sout !== 1'b0) begin errors++; $display("FAIL rts second start: sout=%b, required 0", sout); end
        check_frame(4, 2'b00, 1'b0, "rts second");
        check_idle("rts end", 5'd0);
    endtask

    task automatic test_divisor();
        int w;
        apply_reset();
        cpb = 16'd0; pm = 2'b00; ts = 1'b0; rts_n = 1'b0;
        write_byte(8'h3C);
        wait_start(3, w, "div0");
        check_frame(2, 2'b00, 1'b0, "div0");
        cpb = 16'd8;
        write_byte(8'h5A);
        write_byte(8'hC3);
        checks++;
        if (bus.o_level !== 5'd1 || sout !== 1'b0) begin
            errors++;
            $display("FAIL div push+pop: level=%0d sout=%b, required 1 0", bus.o_level, sout);
        end
        cpb = 16'd16;
        check_frame(8, 2'b00, 1'b0, "div8 current");
        wait_start(2, w, "div16");
        checks++;
        if (w != 0) begin errors++; $display("FAIL div16 gap: %0d idle cycles, required 0", w); end
        check_frame(16, 2'b00, 1'b0, "div16 next");
        check_idle("div end", 5'd0);
    endtask

    task automatic test_overflow();
        int w;
        apply_reset();
        cpb = 16'd4; pm = 2'b00; ts = 1'b0; rts_n = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'h40 + 8'(i));
        bus.i_dat = 8'hEE;
        bus.i_write = 1'b1;
        tick();
        bus.i_write = 1'b0;
        checks++;
        if (bus.o_level !== 5'd16) begin errors++; $display("FAIL ovf level: %0d, required 16", bus.o_level); end
        checks++;
        if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL ovf ready: %b, required 0", bus.o_ready); end
        checks++;
        if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf flag: %b, required 1", bus.o_overflow); end
        rts_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_start(3, w, "burst");
            if (i > 0) begin
                checks++;
                if (w != 0) begin errors++; $display("FAIL burst gap %0d: %0d idle cycles, required 0", i, w); end
            end
            check_frame(4, 2'b00, 1'b0, "burst");
        end
        check_idle("burst end", 5'd0);
    endtask

    task automatic test_reset_midframe();
        int quiet;
        cpb = 16'd8; pm = 2'b00; ts = 1'b0; rts_n = 1'b0;
        write_byte(8'h96);
        write_byte(8'h69);
        for (int i = 0; i < 11; i++) tick();
        checks++;
        if (bus.o_overflow !== 1'b1 || bus.o_level !== 5'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst pre: ovf=%b level=%0d busy=%b, required 1 1 1", bus.o_overflow, bus.o_level, busy);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst line: sout=%b busy=%b, required 1 0", sout, busy);
        end
        checks++;
        if (bus.o_level !== 5'd0 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL midrst fifo: level=%0d ovf=%b, required 0 0", bus.o_level, bus.o_overflow);
        end
        rst_n = 1'b1;
        sb.delete();
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sout === 1'b1 && busy === 1'b0) quiet++;
        end
        checks++;
        if (quiet != 40) begin errors++; $display("FAIL midrst after: %0d quiet cycles, required 40", quiet); end
    endtask

    initial begin
        rst_n = 1'b0;
        cpb = 16'd4; pm = 2'b00; ts = 1'b0; rts_n = 1'b1;
        bus.i_dat = 8'h00;
        bus.i_write = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_rts();
        test_divisor();
        test_overflow();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
